hazard_scoreboard: RTL
======================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NREGW, default 5; register-index width.
REQ-002 Parameter LATW, default 4; long-op latency field width (max latency 2^LATW-1).
REQ-003 Parameter CNTW, default 16; performance-counter width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 rs1_d, rs2_d  in  NREGW  decode-stage source registers.
REQ-007 rd_d  in  NREGW; regwrite_d  in  1  decode-stage destination and its write enable.
REQ-008 long_d  in  1; lat_d  in  LATW  decode instruction is a long-latency op, with its latency in cycles.
REQ-009 rs1_e, rs2_e, rd_e  in  NREGW; regwrite_e, resultsrc_e  in  1  execute-stage fields; resultsrc_e=1 marks a load.
REQ-010 pcsrc_e  in  1  taken branch/jump resolved in execute.
REQ-011 rd_m  in  NREGW; regwrite_m  in  1  memory-stage destination.
REQ-012 rd_w  in  NREGW; regwrite_w  in  1  writeback-stage destination.
REQ-013 clr_cnt  in  1  synchronous clear of the performance counters.
REQ-014 stall_f, stall_d, flush_d, flush_e  out  1  pipeline controls.
REQ-015 forward_ae, forward_be  out  2  ALU operand select: 00 register file, 01 ResultW, 10 ALUResultM.
REQ-016 long_busy  out  1; long_rd  out  NREGW; long_done  out  1  long-op tracker status.
REQ-017 stall_cnt, flush_cnt  out  CNTW  performance counters.

Function
REQ-018 Forwarding SHALL be combinational: forward_ae=10 if regwrite_m & rd_m!=0 & rd_m==rs1_e; else 01 if regwrite_w & rd_w!=0 & rd_w==rs1_e; else 00. forward_be is identical using rs2_e.
REQ-019 Load-use hazard SHALL be: resultsrc_e & regwrite_e & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d).
REQ-020 Long RAW/WAW hazard SHALL be: long_busy & ~long_done & long_rd!=0 & (long_rd==rs1_d | long_rd==rs2_d | (regwrite_d & long_rd==rd_d)).
REQ-021 Structural hazard SHALL be: long_d & long_busy & ~long_done.
REQ-022 stall = any of REQ-019..021, and only when pcsrc_e=0; stall SHALL assert stall_f and stall_d.
REQ-023 flush_e SHALL be pcsrc_e | stall; flush_d SHALL be pcsrc_e; a branch overrides every stall in the same cycle.
REQ-024 Issue SHALL occur when long_d & ~stall & ~pcsrc_e; on issue, long_rd<=rd_d, counter<=max(lat_d,1), long_busy<=1.
REQ-025 While busy, the counter SHALL decrement once per cycle; long_done SHALL be high for exactly one cycle, lat cycles after the issue edge, when counter==1; long_busy SHALL clear on that edge unless a new issue occurs in the same cycle.
REQ-026 An issue in the long_done cycle SHALL be accepted back-to-back with no bubble.
REQ-027 An issue with rd_d=0 SHALL occupy the unit but SHALL NOT create a register hazard.
REQ-028 stall_cnt SHALL increment in every cycle where stall_d=1; flush_cnt SHALL increment in every cycle where pcsrc_e=1; both SHALL saturate at 2^CNTW-1.
REQ-029 clr_cnt SHALL zero both counters, with priority over the increment in that cycle.

Reset
REQ-030 On rst: long_busy=0, long_rd=0, counter=0, long_done=0, stall_cnt=0, flush_cnt=0; combinational outputs follow from the cleared state.
REQ-031 A reset during an outstanding long op SHALL abandon it; no long_done SHALL follow.

Structure
REQ-032 Shared package: forward-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, and the default parameter values.
REQ-033 One sub-module, long_op_tracker (counter, long_rd, long_busy, long_done); the hazard logic and counters stay in the top.

Verification
REQ-034 rd_m=5, regwrite_m=1, rd_w=5, regwrite_w=1, rs1_e=5 -> forward_ae=10; with regwrite_m=0 -> 01; with rd_m=rd_w=0 -> 00.
REQ-035 Load in E with rd_e=3, rs2_d=3 -> stall_f=stall_d=flush_e=1 for one cycle, stall_cnt+1; same with pcsrc_e=1 -> stall=0, flush_d=flush_e=1, flush_cnt+1.
REQ-036 Long issue rd_d=7, lat_d=4, then rs1_d=7 held -> stall for 3 cycles, long_done on the 4th cycle after issue, stall released in that cycle.
REQ-037 lat_d=2 issue, second long_d presented in the long_done cycle -> accepted, long_busy stays 1, long_rd updated, no stall.
REQ-038 lat_d=0 -> long_done one cycle after issue; rst asserted two cycles into a lat_d=8 op -> long_busy=0 and no long_done ever.
REQ-039 CNTW=2 with 5 stall cycles -> stall_cnt=3; clr_cnt together with a stall -> 0.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: forwarding mux selects and
// default widths for register indices, long-op latency and perf counters.
package hazard_scoreboard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int NREGW_DEFAULT = 5;
  localparam int LATW_DEFAULT  = 4;
  localparam int CNTW_DEFAULT  = 16;

endpackage

// File: rtl/hazard_scoreboard_long_op_tracker.sv
// Tracks the single outstanding long-latency op: its destination register and
// a down-counter that flags completion for exactly one cycle.
module long_op_tracker
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREGW = NREGW_DEFAULT,
  parameter int LATW  = LATW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue,
  input  logic [NREGW-1:0] issueRd,
  input  logic [LATW-1:0]  issueLat,
  output logic             busy,
  output logic [NREGW-1:0] busyRd,
  output logic             done
);

  logic [LATW-1:0] counter;
  logic [LATW-1:0] loadLat;

  // A zero latency still needs one cycle to report completion.
  assign loadLat = (issueLat == '0) ? LATW'(1) : issueLat;
  assign done    = busy && (counter == LATW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      busyRd  <= '0;
      counter <= '0;
    end else if (issue) begin
      busy    <= 1'b1;
      busyRd  <= issueRd;
      counter <= loadLat;
    end else if (busy) begin
      counter <= counter - LATW'(1);
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: operand forwarding, load-use / long-op stalls,
// branch flushes, a long-op tracker and saturating stall/flush counters.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREGW = NREGW_DEFAULT,
  parameter int LATW  = LATW_DEFAULT,
  parameter int CNTW  = CNTW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREGW-1:0] rs1_d,
  input  logic [NREGW-1:0] rs2_d,
  input  logic [NREGW-1:0] rd_d,
  input  logic             regwrite_d,
  input  logic             long_d,
  input  logic [LATW-1:0]  lat_d,
  input  logic [NREGW-1:0] rs1_e,
  input  logic [NREGW-1:0] rs2_e,
  input  logic [NREGW-1:0] rd_e,
  input  logic             regwrite_e,
  input  logic             resultsrc_e,
  input  logic             pcsrc_e,
  input  logic [NREGW-1:0] rd_m,
  input  logic             regwrite_m,
  input  logic [NREGW-1:0] rd_w,
  input  logic             regwrite_w,
  input  logic             clr_cnt,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic [1:0]       forward_ae,
  output logic [1:0]       forward_be,
  output logic             long_busy,
  output logic [NREGW-1:0] long_rd,
  output logic             long_done,
  output logic [CNTW-1:0]  stall_cnt,
  output logic [CNTW-1:0]  flush_cnt
);

  logic loadUse;
  logic longHazard;
  logic structHazard;
  logic stall;
  logic issue;

  function automatic logic [1:0] fwdSel(input logic [NREGW-1:0] rs,
                                        input logic             wrM,
                                        input logic [NREGW-1:0] rdM,
                                        input logic             wrW,
                                        input logic [NREGW-1:0] rdW);
    if (wrM && rdM != '0 && rdM == rs)      return FWD_MEM;
    else if (wrW && rdW != '0 && rdW == rs) return FWD_WB;
    else                                    return FWD_RF;
  endfunction

  always_comb begin
    forward_ae = fwdSel(rs1_e, regwrite_m, rd_m, regwrite_w, rd_w);
    forward_be = fwdSel(rs2_e, regwrite_m, rd_m, regwrite_w, rd_w);
  end

  // A completing long op no longer blocks anyone in its done cycle.
  always_comb begin
    loadUse      = resultsrc_e && regwrite_e && rd_e != '0 &&
                   (rd_e == rs1_d || rd_e == rs2_d);
    longHazard   = long_busy && !long_done && long_rd != '0 &&
                   (long_rd == rs1_d || long_rd == rs2_d ||
                    (regwrite_d && long_rd == rd_d));
    structHazard = long_d && long_busy && !long_done;
    stall        = (loadUse || longHazard || structHazard) && !pcsrc_e;
    issue        = long_d && !stall && !pcsrc_e;
    stall_f      = stall;
    stall_d      = stall;
    flush_d      = pcsrc_e;
    flush_e      = pcsrc_e || stall;
  end

  long_op_tracker #(
    .NREGW(NREGW),
    .LATW (LATW)
  ) uTracker (
    .clk     (clk),
    .rst     (rst),
    .issue   (issue),
    .issueRd (rd_d),
    .issueLat(lat_d),
    .busy    (long_busy),
    .busyRd  (long_rd),
    .done    (long_done)
  );

  // Counters hold at all-ones; a clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_d && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + CNTW'(1);
      end
      if (pcsrc_e && flush_cnt != '1) begin
        flush_cnt <= flush_cnt + CNTW'(1);
      end
    end
  end

endmodule
